// File: rtl/otp_boot_loader.sv
// rtl/otp_boot_loader.sv - boot-time OTP shadow loader copying trim bytes into the register file
// Sequences csb/load/strobe reads of N_BYTES OTP bytes and writes each one over the xbus.
module otp_boot_loader #(
  parameter int         N_BYTES   = 16,
  parameter int         OTP_AW    = 7,
  parameter logic [7:0] BASE_ADDR = 8'd9,
  parameter int         T_SU      = 4,
  parameter int         T_STB     = 10,
  parameter int         T_HD      = 2,
  parameter bit         AUTO_LOAD = 1'b1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              start_load,
  input  logic [7:0]        i_otp_q,
  output logic              o_otp_csb,
  output logic              o_otp_load,
  output logic              o_otp_strobe,
  output logic              o_otp_pgenb,
  output logic [OTP_AW-1:0] o_otp_addr,
  output logic [7:0]        xbus_addr,
  output logic [7:0]        xbus_din,
  output logic              xbus_wr,
  output logic              load_busy,
  output logic              load_done
);

  localparam int T_MAX = (T_SU > T_STB) ? ((T_SU > T_HD) ? T_SU : T_HD)
                                        : ((T_STB > T_HD) ? T_STB : T_HD);
  localparam int TW = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [TW-1:0] SU_LD    = TW'(T_SU - 1);
  localparam logic [TW-1:0] STB_LD   = TW'(T_STB - 1);
  localparam logic [TW-1:0] HD_LD    = TW'(T_HD - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BYTES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WRITE, DONE} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_ld;
  logic [IW-1:0] index;
  logic [7:0]    data_q;
  logic          auto_pend;
  logic          start_low_q;
  logic          start_rise;
  logic          seq_active;

  // start_low_q only arms after start_load has been seen low, so a level held through reset never fires
  assign start_rise = start_load & start_low_q;

  always_comb begin
    state_n      = state;
    timer_ld     = '0;
    seq_active   = 1'b0;
    o_otp_csb    = 1'b1;
    o_otp_load   = 1'b0;
    o_otp_strobe = 1'b0;
    o_otp_pgenb  = 1'b1;
    o_otp_addr   = '0;
    xbus_addr    = '0;
    xbus_din     = '0;
    xbus_wr      = 1'b0;

    case (state)
      IDLE:    if (auto_pend || start_rise) state_n = SETUP;
      SETUP:   if (timer == '0) state_n = STROBE;
      STROBE:  if (timer == '0) state_n = HOLD;
      HOLD:    if (timer == '0) state_n = WRITE;
      WRITE:   state_n = (index == LAST_IDX) ? DONE : SETUP;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    case (state_n)
      SETUP:   timer_ld = SU_LD;
      STROBE:  timer_ld = STB_LD;
      HOLD:    timer_ld = HD_LD;
      default: timer_ld = '0;
    endcase

    seq_active = (state == SETUP) || (state == STROBE) || (state == HOLD) || (state == WRITE);
    if (seq_active) begin
      o_otp_csb  = 1'b0;
      o_otp_load = 1'b1;
      o_otp_addr = OTP_AW'(index);
    end
    o_otp_strobe = (state == STROBE);
    if (state == WRITE) begin
      xbus_wr   = 1'b1;
      xbus_addr = BASE_ADDR + 8'(index);
      xbus_din  = data_q;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      index       <= '0;
      data_q      <= '0;
      auto_pend   <= AUTO_LOAD;
      start_low_q <= 1'b0;
      load_busy   <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      state       <= state_n;
      auto_pend   <= 1'b0;
      start_low_q <= ~start_load;

      // timer reloads on every state entry and saturates at zero
      if (state_n != state) begin
        timer <= timer_ld;
      end else if (timer != '0) begin
        timer <= timer - 1'b1;
      end

      if (state == STROBE && timer == '0) begin
        data_q <= i_otp_q;
      end

      if (state == IDLE && state_n == SETUP) begin
        index     <= '0;
        load_busy <= 1'b1;
        load_done <= 1'b0;
      end else if (state == WRITE && state_n == SETUP) begin
        index <= index + 1'b1;
      end

      if (state == DONE) begin
        load_busy <= 1'b0;
        load_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_otp_boot_loader.sv
// tb/tb_otp_boot_loader.sv - randomized self-checking bench for otp_boot_loader
// Expected writes and cycle counts come from the load rules, not from the FSM structure.
module tb_otp_boot_loader;

  localparam int          NB_A   = 16;
  localparam int          PER_A  = 4 + 10 + 2 + 1;
  localparam int          NB_M   = 4;
  localparam int          PER_M  = 2 + 3 + 1 + 1;
  localparam int          PER_S  = 1 + 1 + 1 + 1;
  localparam logic [29:0] RST_OUTS = {1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  int cyc = 0;
  always @(posedge sys_clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem_a [128];
  logic [7:0] mem_b [128];

  // default-parameter instance
  logic       a_rst_n = 1'b0, a_start = 1'b0;
  logic [7:0] a_q, a_xaddr, a_xdin;
  logic [6:0] a_oaddr;
  logic       a_csb, a_load, a_stb, a_pgenb, a_xwr, a_busy, a_done;
  assign a_q = mem_a[a_oaddr];

  otp_boot_loader dut_a (
    .sys_clk(sys_clk), .rst_n(a_rst_n), .start_load(a_start), .i_otp_q(a_q),
    .o_otp_csb(a_csb), .o_otp_load(a_load), .o_otp_strobe(a_stb), .o_otp_pgenb(a_pgenb),
    .o_otp_addr(a_oaddr), .xbus_addr(a_xaddr), .xbus_din(a_xdin), .xbus_wr(a_xwr),
    .load_busy(a_busy), .load_done(a_done)
  );

  // manual-start instance
  logic       m_rst_n = 1'b0, m_start = 1'b1;
  logic [7:0] m_q, m_xaddr, m_xdin;
  logic [6:0] m_oaddr;
  logic       m_csb, m_load, m_stb, m_pgenb, m_xwr, m_busy, m_done;
  assign m_q = mem_b[m_oaddr];

  otp_boot_loader #(.N_BYTES(NB_M), .T_SU(2), .T_STB(3), .T_HD(1), .AUTO_LOAD(1'b0)) dut_m (
    .sys_clk(sys_clk), .rst_n(m_rst_n), .start_load(m_start), .i_otp_q(m_q),
    .o_otp_csb(m_csb), .o_otp_load(m_load), .o_otp_strobe(m_stb), .o_otp_pgenb(m_pgenb),
    .o_otp_addr(m_oaddr), .xbus_addr(m_xaddr), .xbus_din(m_xdin), .xbus_wr(m_xwr),
    .load_busy(m_busy), .load_done(m_done)
  );

  // one- and two-byte instances at the top of the address map
  logic       b_rst_n = 1'b0, b_start = 1'b0;
  logic [7:0] s1_q, s1_xaddr, s1_xdin, s2_q, s2_xaddr, s2_xdin;
  logic [6:0] s1_oaddr, s2_oaddr;
  logic       s1_csb, s1_load, s1_stb, s1_pgenb, s1_xwr, s1_busy, s1_done;
  logic       s2_csb, s2_load, s2_stb, s2_pgenb, s2_xwr, s2_busy, s2_done;
  assign s1_q = mem_b[s1_oaddr];
  assign s2_q = mem_b[s2_oaddr];

  otp_boot_loader #(.N_BYTES(1), .BASE_ADDR(8'hFF), .T_SU(1), .T_STB(1), .T_HD(1)) dut_s1 (
    .sys_clk(sys_clk), .rst_n(b_rst_n), .start_load(b_start), .i_otp_q(s1_q),
    .o_otp_csb(s1_csb), .o_otp_load(s1_load), .o_otp_strobe(s1_stb), .o_otp_pgenb(s1_pgenb),
    .o_otp_addr(s1_oaddr), .xbus_addr(s1_xaddr), .xbus_din(s1_xdin), .xbus_wr(s1_xwr),
    .load_busy(s1_busy), .load_done(s1_done)
  );

  otp_boot_loader #(.N_BYTES(2), .BASE_ADDR(8'hFF), .T_SU(1), .T_STB(1), .T_HD(1)) dut_s2 (
    .sys_clk(sys_clk), .rst_n(b_rst_n), .start_load(b_start), .i_otp_q(s2_q),
    .o_otp_csb(s2_csb), .o_otp_load(s2_load), .o_otp_strobe(s2_stb), .o_otp_pgenb(s2_pgenb),
    .o_otp_addr(s2_oaddr), .xbus_addr(s2_xaddr), .xbus_din(s2_xdin), .xbus_wr(s2_xwr),
    .load_busy(s2_busy), .load_done(s2_done)
  );

  logic [29:0] a_outs, m_outs, s1_outs;
  assign a_outs  = {a_csb, a_pgenb, a_load, a_stb, a_oaddr, a_xaddr, a_xdin, a_xwr, a_busy, a_done};
  assign m_outs  = {m_csb, m_pgenb, m_load, m_stb, m_oaddr, m_xaddr, m_xdin, m_xwr, m_busy, m_done};
  assign s1_outs = {s1_csb, s1_pgenb, s1_load, s1_stb, s1_oaddr, s1_xaddr, s1_xdin, s1_xwr, s1_busy, s1_done};

  // event logs, sampled on the falling edge
  logic [7:0] a_wa[$], a_wd[$], m_wa[$], m_wd[$], s1_wa[$], s1_wd[$], s2_wa[$], s2_wd[$];
  int a_wc[$], a_sr[$], a_sl[$], a_cf[$];
  int a_busy_cnt = 0, a_pg_bad = 0, m_busy_cnt = 0, s1_busy_cnt = 0, s2_busy_cnt = 0;
  logic a_stb_p = 1'b0, a_csb_p = 1'b1;

  always @(negedge sys_clk) begin
    if (a_xwr) begin a_wa.push_back(a_xaddr); a_wd.push_back(a_xdin); a_wc.push_back(cyc); end
    if (a_busy) a_busy_cnt++;
    if (a_stb && !a_stb_p) a_sr.push_back(cyc);
    if (!a_stb && a_stb_p) a_sl.push_back(cyc - 1);
    if (!a_csb && a_csb_p) a_cf.push_back(cyc);
    if (a_pgenb !== 1'b1) a_pg_bad++;
    a_stb_p = a_stb;
    a_csb_p = a_csb;
    if (m_xwr) begin m_wa.push_back(m_xaddr); m_wd.push_back(m_xdin); end
    if (m_busy) m_busy_cnt++;
    if (s1_xwr) begin s1_wa.push_back(s1_xaddr); s1_wd.push_back(s1_xdin); end
    if (s1_busy) s1_busy_cnt++;
    if (s2_xwr) begin s2_wa.push_back(s2_xaddr); s2_wd.push_back(s2_xdin); end
    if (s2_busy) s2_busy_cnt++;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic clear_a();
    a_wa.delete(); a_wd.delete(); a_wc.delete(); a_sr.delete(); a_sl.delete(); a_cf.delete();
    a_busy_cnt = 0;
    a_pg_bad   = 0;
  endtask

  task automatic wait_done_a(input int budget, input string tag);
    int k;
    k = 0;
    while (!(a_done === 1'b1 && a_busy === 1'b0) && k < budget) begin
      step();
      k++;
    end
    n_checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0)
      $display("FAIL %s_timeout: done=%b busy=%b after %0d cycles, required done=1 busy=0", tag, a_done, a_busy, k);
    else n_pass++;
  endtask

  task automatic test_reset();
    step(3);
    n_checks++;
    if (a_outs !== RST_OUTS) $display("FAIL reset_a_outputs: got %h, required %h", a_outs, RST_OUTS);
    else n_pass++;
    n_checks++;
    if (m_outs !== RST_OUTS) $display("FAIL reset_m_outputs: got %h, required %h", m_outs, RST_OUTS);
    else n_pass++;
    n_checks++;
    if (s1_outs !== RST_OUTS) $display("FAIL reset_s1_outputs: got %h, required %h", s1_outs, RST_OUTS);
    else n_pass++;
    n_checks++;
    if (a_wa.size() != 0) $display("FAIL reset_no_write: got %0d writes, required 0", a_wa.size());
    else n_pass++;
  endtask

  task automatic test_auto_load();
    logic [7:0] ea, ed;
    for (int i = 0; i < 128; i++) mem_a[i] = 8'(i) ^ 8'hA5;
    clear_a();
    a_rst_n = 1'b1;
    wait_done_a(400, "auto_load");
    n_checks++;
    if (a_wa.size() != NB_A) $display("FAIL auto_write_count: got %0d, required %0d", a_wa.size(), NB_A);
    else n_pass++;
    for (int i = 0; i < NB_A && i < a_wa.size(); i++) begin
      ea = 8'((9 + i) % 256);
      ed = 8'(i) ^ 8'hA5;
      n_checks++;
      if (a_wa[i] !== ea || a_wd[i] !== ed)
        $display("FAIL auto_write_%0d: got addr %h data %h, required addr %h data %h", i, a_wa[i], a_wd[i], ea, ed);
      else n_pass++;
    end
    n_checks++;
    if (a_busy_cnt != NB_A * PER_A + 1) $display("FAIL auto_busy_cycles: got %0d, required %0d", a_busy_cnt, NB_A * PER_A + 1);
    else n_pass++;
  endtask

  task automatic test_timing();
    n_checks++;
    if (a_cf.size() != 1 || a_sr.size() != NB_A)
      $display("FAIL timing_edges: got %0d csb falls %0d strobe rises, required 1 and %0d", a_cf.size(), a_sr.size(), NB_A);
    else n_pass++;
    if (a_cf.size() > 0 && a_sr.size() > 0) begin
      n_checks++;
      if (a_sr[0] - a_cf[0] != 4) $display("FAIL timing_setup: got %0d cycles, required 4", a_sr[0] - a_cf[0]);
      else n_pass++;
    end
    for (int k = 0; k < NB_A; k++) begin
      if (k < a_sr.size() && k < a_sl.size() && k < a_wc.size()) begin
        n_checks++;
        if (a_sl[k] - a_sr[k] + 1 != 10 || a_wc[k] - a_sl[k] != 3 || (k > 0 && a_sr[k] - a_sr[k-1] != PER_A))
          $display("FAIL timing_byte_%0d: got strobe width %0d, write gap %0d, required 10 and 3 with period %0d",
                   k, a_sl[k] - a_sr[k] + 1, a_wc[k] - a_sl[k], PER_A);
        else n_pass++;
      end
    end
    n_checks++;
    if (a_pg_bad != 0) $display("FAIL timing_pgenb: got %0d cycles with pgenb low, required 0", a_pg_bad);
    else n_pass++;
  endtask

  task automatic test_retrigger();
    logic [7:0] ea;
    for (int i = 0; i < 128; i++) mem_a[i] = 8'($urandom);
    clear_a();
    a_start = 1'b1;
    step();
    n_checks++;
    if (a_busy !== 1'b1 || a_done !== 1'b0) $display("FAIL retrig_start: got busy=%b done=%b, required busy=1 done=0", a_busy, a_done);
    else n_pass++;
    for (int t = 0; t < 4; t++) begin
      step($urandom_range(5, 40));
      a_start = ~a_start;
    end
    step(5);
    a_start = 1'b0;
    wait_done_a(400, "retrigger");
    n_checks++;
    if (a_wa.size() != NB_A) $display("FAIL retrig_write_count: got %0d, required %0d", a_wa.size(), NB_A);
    else n_pass++;
    for (int i = 0; i < NB_A && i < a_wa.size(); i++) begin
      ea = 8'((9 + i) % 256);
      n_checks++;
      if (a_wa[i] !== ea || a_wd[i] !== mem_a[i])
        $display("FAIL retrig_write_%0d: got addr %h data %h, required addr %h data %h", i, a_wa[i], a_wd[i], ea, mem_a[i]);
      else n_pass++;
    end
    n_checks++;
    if (a_busy_cnt != NB_A * PER_A + 1) $display("FAIL retrig_busy_cycles: got %0d, required %0d", a_busy_cnt, NB_A * PER_A + 1);
    else n_pass++;
  endtask

  task automatic test_done_edge();
    int k;
    clear_a();
    a_start = 1'b1;
    step(3);
    a_start = 1'b0;
    k = 0;
    while (a_wa.size() < NB_A && k < 400) begin step(); k++; end
    // the cycle right after the last write is the DONE cycle
    n_checks++;
    if (a_wa.size() != NB_A || a_busy !== 1'b1 || a_csb !== 1'b1 || a_xwr !== 1'b0)
      $display("FAIL done_cycle: got writes=%0d busy=%b csb=%b wr=%b, required %0d 1 1 0", a_wa.size(), a_busy, a_csb, a_xwr, NB_A);
    else n_pass++;
    a_start = 1'b1;
    step(40);
    n_checks++;
    if (a_wa.size() != NB_A || a_busy !== 1'b0 || a_done !== 1'b1)
      $display("FAIL done_edge_ignored: got writes=%0d busy=%b done=%b, required %0d 0 1", a_wa.size(), a_busy, a_done, NB_A);
    else n_pass++;
    a_start = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int k;
    logic [7:0] ea;
    clear_a();
    a_start = 1'b1;
    k = 0;
    while (a_sr.size() < 8 && k < 400) begin step(); k++; end
    n_checks++;
    if (a_sr.size() != 8) $display("FAIL midrst_reach_byte7: got %0d strobes, required 8", a_sr.size());
    else n_pass++;
    step(3);
    #1 a_rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_outs !== RST_OUTS || a_stb !== 1'b0) $display("FAIL midrst_outputs: got %h, required %h", a_outs, RST_OUTS);
    else n_pass++;
    a_start = 1'b0;
    step(4);
    n_checks++;
    if (a_wa.size() != 7) $display("FAIL midrst_no_partial: got %0d writes, required 7", a_wa.size());
    else n_pass++;
    clear_a();
    a_rst_n = 1'b1;
    wait_done_a(400, "midrst_restart");
    n_checks++;
    if (a_wa.size() != NB_A || a_busy_cnt != NB_A * PER_A + 1)
      $display("FAIL midrst_restart: got %0d writes %0d busy cycles, required %0d and %0d", a_wa.size(), a_busy_cnt, NB_A, NB_A * PER_A + 1);
    else n_pass++;
    for (int i = 0; i < NB_A && i < a_wa.size(); i++) begin
      ea = 8'((9 + i) % 256);
      n_checks++;
      if (a_wa[i] !== ea || a_wd[i] !== mem_a[i])
        $display("FAIL midrst_write_%0d: got addr %h data %h, required addr %h data %h", i, a_wa[i], a_wd[i], ea, mem_a[i]);
      else n_pass++;
    end
  endtask

  task automatic test_manual_start();
    int k;
    logic [7:0] ea;
    for (int i = 0; i < 128; i++) mem_b[i] = 8'($urandom);
    m_rst_n = 1'b1;
    step(30);
    n_checks++;
    if (m_wa.size() != 0 || m_busy !== 1'b0 || m_done !== 1'b0)
      $display("FAIL manual_held_start: got writes=%0d busy=%b done=%b, required 0 0 0", m_wa.size(), m_busy, m_done);
    else n_pass++;
    m_start = 1'b0;
    step(2);
    m_start = 1'b1;
    m_busy_cnt = 0;
    step();
    n_checks++;
    if (m_busy !== 1'b1 || m_csb !== 1'b0 || m_load !== 1'b1)
      $display("FAIL manual_next_cycle: got busy=%b csb=%b load=%b, required 1 0 1", m_busy, m_csb, m_load);
    else n_pass++;
    k = 0;
    while (!(m_done === 1'b1 && m_busy === 1'b0) && k < 100) begin step(); k++; end
    n_checks++;
    if (m_wa.size() != NB_M || m_busy_cnt != NB_M * PER_M + 1 || m_done !== 1'b1)
      $display("FAIL manual_load: got %0d writes %0d busy cycles done=%b, required %0d %0d 1", m_wa.size(), m_busy_cnt, m_done, NB_M, NB_M * PER_M + 1);
    else n_pass++;
    for (int i = 0; i < NB_M && i < m_wa.size(); i++) begin
      ea = 8'((9 + i) % 256);
      n_checks++;
      if (m_wa[i] !== ea || m_wd[i] !== mem_b[i])
        $display("FAIL manual_write_%0d: got addr %h data %h, required addr %h data %h", i, m_wa[i], m_wd[i], ea, mem_b[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    int k;
    b_rst_n = 1'b1;
    k = 0;
    while (!(s2_done === 1'b1 && s1_done === 1'b1) && k < 60) begin step(); k++; end
    n_checks++;
    if (s1_wa.size() != 1 || s1_busy_cnt != PER_S + 1 || s1_done !== 1'b1)
      $display("FAIL wrap_single: got %0d writes %0d busy cycles done=%b, required 1 %0d 1", s1_wa.size(), s1_busy_cnt, s1_done, PER_S + 1);
    else n_pass++;
    if (s1_wa.size() > 0) begin
      n_checks++;
      if (s1_wa[0] !== 8'hFF || s1_wd[0] !== mem_b[0])
        $display("FAIL wrap_single_write: got addr %h data %h, required addr ff data %h", s1_wa[0], s1_wd[0], mem_b[0]);
      else n_pass++;
    end
    n_checks++;
    if (s2_wa.size() != 2 || s2_busy_cnt != 2 * PER_S + 1)
      $display("FAIL wrap_pair: got %0d writes %0d busy cycles, required 2 %0d", s2_wa.size(), s2_busy_cnt, 2 * PER_S + 1);
    else n_pass++;
    if (s2_wa.size() == 2) begin
      n_checks++;
      if (s2_wa[0] !== 8'hFF || s2_wd[0] !== mem_b[0] || s2_wa[1] !== 8'h00 || s2_wd[1] !== mem_b[1])
        $display("FAIL wrap_pair_writes: got %h/%h %h/%h, required ff/%h 00/%h",
                 s2_wa[0], s2_wd[0], s2_wa[1], s2_wd[1], mem_b[0], mem_b[1]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_auto_load();
    test_timing();
    test_retrigger();
    test_done_edge();
    test_reset_mid();
    test_manual_start();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
